// File: rtl/pf_ddr4_ca_pkg.sv
// Shared types and helpers for the DDR4 command/address lane delay controller.
package pf_ddr4_ca_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_CMP,
    ST_MOVE,
    ST_DONE,
    ST_ERR
  } ca_state_e;

  // Bit offset of a lane's field inside a packed per-lane bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pf_ddr4_ca_tx_pipe.sv
// Single register stage for the per-lane TX/OE nibbles.
// The OE nibble of a lane being adjusted is zeroed on its way into the register.
module pf_ddr4_ca_tx_pipe
  import pf_ddr4_ca_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int DATA_W    = 4
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic [NUM_LANES*DATA_W-1:0]   tx_in,
  input  logic [NUM_LANES*DATA_W-1:0]   oe_in,
  input  logic [NUM_LANES-1:0]          oe_mask,
  output logic [NUM_LANES*DATA_W-1:0]   tx_out,
  output logic [NUM_LANES*DATA_W-1:0]   oe_out
);

  logic [NUM_LANES*DATA_W-1:0] tx_reg;
  logic [NUM_LANES*DATA_W-1:0] oe_reg;
  logic [NUM_LANES*DATA_W-1:0] oe_next;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign oe_next[lane_lsb(gi, DATA_W) +: DATA_W] =
      oe_mask[gi] ? '0 : oe_in[lane_lsb(gi, DATA_W) +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      tx_reg <= '0;
      oe_reg <= '0;
    end else begin
      tx_reg <= tx_in;
      oe_reg <= oe_next;
    end
  end

  assign tx_out = tx_reg;
  assign oe_out = oe_reg;

endmodule

// File: rtl/pf_ddr4_ca_lane_delay_ctrl.sv
// DDR4 C/A lane controller: registers TX/OE nibbles and sequences each lane's
// output delay line (LOAD/MOVE/DIRECTION) from one request channel, tracking taps.
module pf_ddr4_ca_lane_delay_ctrl
  import pf_ddr4_ca_pkg::*;
#(
  parameter int NUM_LANES  = 8,
  parameter int DATA_W     = 4,
  parameter int TAP_W      = 8,
  parameter int MOVE_GAP   = 3,
  parameter bit QUIESCE_OE = 1'b1,
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                          FAB_CLK,
  input  logic                          TX_SYNC_RST,
  input  logic [NUM_LANES*DATA_W-1:0]   TX_DATA_IN,
  input  logic [NUM_LANES*DATA_W-1:0]   OE_DATA_IN,
  output logic [NUM_LANES*DATA_W-1:0]   TX_DATA_OUT,
  output logic [NUM_LANES*DATA_W-1:0]   OE_DATA_OUT,
  input  logic                          REQ_VALID,
  output logic                          REQ_READY,
  input  logic [LANE_W-1:0]             REQ_LANE,
  input  logic [TAP_W-1:0]              REQ_TAP,
  input  logic                          REQ_LOAD,
  output logic                          DONE,
  output logic                          ERR,
  output logic [NUM_LANES-1:0]          DELAY_LINE_LOAD,
  output logic [NUM_LANES-1:0]          DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]          DELAY_LINE_DIRECTION,
  input  logic [NUM_LANES-1:0]          DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES*TAP_W-1:0]    TAP_POS,
  output logic [NUM_LANES-1:0]          LANE_CAL
);

  localparam int LANE_SPAN = 1 << LANE_W;
  localparam int WAIT_W    = $clog2(MOVE_GAP + 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MOVE_GAP - 1);

  ca_state_e            state_reg, state_next;
  logic [LANE_W-1:0]    lane_reg;
  logic [TAP_W-1:0]     target_reg;
  logic                 load_req_reg;
  logic                 dir_reg;
  logic                 oor_reg;
  logic                 from_move_reg;
  logic [WAIT_W-1:0]    wait_cnt_reg;
  logic [TAP_W-1:0]     tap_reg [NUM_LANES];
  logic [NUM_LANES-1:0] cal_reg;

  logic [LANE_SPAN-1:0] lane_valid;
  logic [LANE_SPAN-1:0] cal_ext;
  logic [TAP_W-1:0]     cur_tap;
  logic                 oor_now;
  logic                 dir_out;
  logic                 quiesce_state;
  logic [NUM_LANES-1:0] oe_mask;

  // Pad lane lookups to the full index range so an illegal lane reads as invalid.
  for (genvar gi = 0; gi < LANE_SPAN; gi++) begin : g_span
    if (gi < NUM_LANES) begin : g_real
      assign lane_valid[gi] = 1'b1;
      assign cal_ext[gi]    = cal_reg[gi];
    end else begin : g_pad
      assign lane_valid[gi] = 1'b0;
      assign cal_ext[gi]    = 1'b0;
    end
  end

  assign cur_tap = tap_reg[lane_reg];
  assign oor_now = DELAY_LINE_OUT_OF_RANGE[lane_reg];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (REQ_VALID) begin
          if (!lane_valid[REQ_LANE] || (!REQ_LOAD && !cal_ext[REQ_LANE]))
            state_next = ST_ERR;
          else if (REQ_LOAD)
            state_next = ST_LOAD;
          else
            state_next = ST_CMP;
        end
      end
      ST_LOAD: state_next = ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt_reg == '0)
          state_next = (from_move_reg && (oor_reg || oor_now)) ? ST_ERR : ST_CMP;
      end
      ST_CMP:  state_next = (cur_tap == target_reg) ? ST_DONE : ST_MOVE;
      ST_MOVE: state_next = ST_WAIT;
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state_reg     <= ST_IDLE;
      lane_reg      <= '0;
      target_reg    <= '0;
      load_req_reg  <= 1'b0;
      dir_reg       <= 1'b0;
      oor_reg       <= 1'b0;
      from_move_reg <= 1'b0;
      wait_cnt_reg  <= '0;
      cal_reg       <= '0;
      for (int i = 0; i < NUM_LANES; i++) tap_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          dir_reg <= 1'b0;
          if (REQ_VALID) begin
            lane_reg     <= REQ_LANE;
            target_reg   <= REQ_TAP;
            load_req_reg <= REQ_LOAD;
          end
        end
        ST_LOAD: begin
          tap_reg[lane_reg] <= '0;
          from_move_reg     <= 1'b0;
          oor_reg           <= 1'b0;
          wait_cnt_reg      <= WAIT_INIT;
        end
        ST_CMP: dir_reg <= (target_reg > cur_tap);
        ST_MOVE: begin
          tap_reg[lane_reg] <= dir_reg ? cur_tap + TAP_W'(1) : cur_tap - TAP_W'(1);
          from_move_reg     <= 1'b1;
          oor_reg           <= 1'b0;
          wait_cnt_reg      <= WAIT_INIT;
        end
        ST_WAIT: begin
          if (wait_cnt_reg != '0) wait_cnt_reg <= wait_cnt_reg - WAIT_W'(1);
          // Step back exactly once, however long the IOD holds its flag.
          if (from_move_reg && oor_now && !oor_reg) begin
            oor_reg           <= 1'b1;
            tap_reg[lane_reg] <= dir_reg ? cur_tap - TAP_W'(1) : cur_tap + TAP_W'(1);
          end
        end
        ST_DONE: if (load_req_reg) cal_reg[lane_reg] <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    dir_out = 1'b0;
    case (state_reg)
      ST_CMP:           dir_out = (target_reg > cur_tap);
      ST_MOVE, ST_WAIT: dir_out = dir_reg;
      default:          dir_out = 1'b0;
    endcase
  end

  assign quiesce_state = (state_reg == ST_LOAD) || (state_reg == ST_WAIT) ||
                         (state_reg == ST_CMP)  || (state_reg == ST_MOVE);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic active;
    assign active                   = (lane_reg == LANE_W'(gi));
    assign DELAY_LINE_LOAD[gi]      = active && (state_reg == ST_LOAD);
    assign DELAY_LINE_MOVE[gi]      = active && (state_reg == ST_MOVE);
    assign DELAY_LINE_DIRECTION[gi] = active && dir_out;
    assign oe_mask[gi]              = QUIESCE_OE && active && quiesce_state;
    assign TAP_POS[lane_lsb(gi, TAP_W) +: TAP_W] = tap_reg[gi];
  end

  assign REQ_READY = (state_reg == ST_IDLE);
  assign DONE      = (state_reg == ST_DONE);
  assign ERR       = (state_reg == ST_ERR);
  assign LANE_CAL  = cal_reg;

  pf_ddr4_ca_tx_pipe #(
    .NUM_LANES (NUM_LANES),
    .DATA_W    (DATA_W)
  ) u_tx_pipe (
    .clk     (FAB_CLK),
    .srst    (TX_SYNC_RST),
    .tx_in   (TX_DATA_IN),
    .oe_in   (OE_DATA_IN),
    .oe_mask (oe_mask),
    .tx_out  (TX_DATA_OUT),
    .oe_out  (OE_DATA_OUT)
  );

endmodule
